// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op encoding, state enum and decode for the mul/div unit
package md_pkg;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7,
        MD_MULW   = 4'd8,
        MD_DIVW   = 4'd9,
        MD_DIVUW  = 4'd10,
        MD_REMW   = 4'd11,
        MD_REMUW  = 4'd12,
        MD_RSVD   = 4'd13
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } md_state_e;

    localparam int W_ITER = 32;
    localparam int D_ITER = 64;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OP_32 = 7'b0111011;

    // OP maps funct3 straight onto codes 0-7; OP-32 only defines funct3 0,4,5,6,7.
    function automatic md_op_e md_decode(input logic [6:0] opcode, input logic [2:0] funct3);
        md_op_e o;
        o = MD_RSVD;
        if (opcode == OPC_OP) begin
            o = md_op_e'({1'b0, funct3});
        end else if (opcode == OPC_OP_32) begin
            case (funct3)
                3'd0:    o = MD_MULW;
                3'd4:    o = MD_DIVW;
                3'd5:    o = MD_DIVUW;
                3'd6:    o = MD_REMW;
                3'd7:    o = MD_REMUW;
                default: o = MD_RSVD;
            endcase
        end
        return o;
    endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV64M multiply/divide, one bit per cycle
module mul_div_unit
    import md_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e         state;
    logic [6:0]        count;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] acc_nxt;
    logic [XLEN-1:0]   b_q;
    md_op_e            op_q;
    logic              w_q;
    logic              neg_q;
    logic              rneg_q;
    logic              is_mul_q;

    md_op_e          op_e;
    logic            rsvd, is_w, is_mul, is_rem, sa, sb;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, most_neg, w_a, spec_res;
    logic            neg_a, neg_b, div_zero, div_ovf, special;

    logic [XLEN:0]     mul_sum, div_sh, div_diff, div_rem;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fin;
    logic              unused_bits;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        return {{(XLEN-32){x[31]}}, x[31:0]};
    endfunction

    assign op_e     = md_op_e'(op);
    assign is_mul_q = op_q inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_MULW};

    always_comb begin
        rsvd   = (op > 4'd12);
        is_w   = op[3] & ~rsvd;
        is_mul = op_e inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_MULW};
        is_rem = op_e inside {MD_REM, MD_REMU, MD_REMW, MD_REMUW};
        sa     = op_e inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM, MD_MULW, MD_DIVW, MD_REMW};
        sb     = op_e inside {MD_MUL, MD_MULH, MD_DIV, MD_REM, MD_MULW, MD_DIVW, MD_REMW};
        ext_a  = is_w ? (sa ? sext_w(rs1) : {{(XLEN-32){1'b0}}, rs1[31:0]}) : rs1;
        ext_b  = is_w ? (sb ? sext_w(rs2) : {{(XLEN-32){1'b0}}, rs2[31:0]}) : rs2;
        neg_a  = sa & ext_a[XLEN-1];
        neg_b  = sb & ext_b[XLEN-1];
        mag_a  = neg_a ? -ext_a : ext_a;
        mag_b  = neg_b ? -ext_b : ext_b;
        // W operands are already sign-extended, so the 32-bit most-negative compares at full width.
        most_neg = is_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
        div_zero = ~is_mul & ~rsvd & (ext_b == '0);
        div_ovf  = ~is_mul & ~rsvd & sa & sb & (ext_a == most_neg) & (&ext_b);
        special  = rsvd | div_zero | div_ovf;
        w_a      = is_w ? sext_w(ext_a) : ext_a;
        spec_res = '0;
        if (div_zero) begin
            spec_res = is_rem ? w_a : '1;
        end else if (div_ovf) begin
            spec_res = is_rem ? '0 : w_a;
        end
    end

    // Multiply shifts the accumulator right; divide shifts it left with the quotient entering at bit 0.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, b_q};
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_sh - {1'b0, b_q};
        div_ge   = (div_sh >= {1'b0, b_q});
        div_rem  = div_ge ? div_diff : div_sh;
        if (is_mul_q) begin
            acc_nxt = acc[0] ? {mul_sum, acc[XLEN-1:1]} : {1'b0, acc[2*XLEN-1:1]};
        end else begin
            acc_nxt = {div_rem[XLEN-1:0], acc[XLEN-2:0], div_ge};
        end
    end

    assign unused_bits = div_rem[XLEN];

    // After only 32 multiply iterations the product sits 32 bits up in the accumulator.
    always_comb begin
        prod   = w_q ? {32'b0, acc_nxt[2*XLEN-1:32]} : acc_nxt;
        prod_s = neg_q ? -prod : prod;
        quo_s  = neg_q ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
        rem_s  = rneg_q ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
        case (op_q)
            MD_MUL:                       fin = prod_s[XLEN-1:0];
            MD_MULW:                      fin = sext_w(prod_s[XLEN-1:0]);
            MD_MULH, MD_MULHSU, MD_MULHU: fin = prod_s[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              fin = quo_s;
            MD_REM, MD_REMU:              fin = rem_s;
            MD_DIVW, MD_DIVUW:            fin = sext_w(quo_s);
            MD_REMW, MD_REMUW:            fin = sext_w(rem_s);
            default:                      fin = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            count  <= '0;
            acc    <= '0;
            b_q    <= '0;
            op_q   <= MD_MUL;
            w_q    <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_CALC: begin
                    if (kill) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc   <= acc_nxt;
                        count <= count - 7'd1;
                        if (count == 7'd1) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= fin;
                        end
                    end
                end
                default: begin
                    // DONE accepts a new start so back-to-back issue has no dead cycle.
                    if (kill || !start) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        op_q   <= op_e;
                        w_q    <= is_w;
                        neg_q  <= neg_a ^ neg_b;
                        rneg_q <= neg_a;
                        busy   <= 1'b1;
                        count  <= is_w ? 7'(W_ITER) : 7'(D_ITER);
                        if (is_mul) begin
                            acc <= {{XLEN{1'b0}}, mag_b};
                            b_q <= mag_a;
                        end else begin
                            acc <= {{XLEN{1'b0}}, is_w ? {mag_a[31:0], 32'b0} : mag_a};
                            b_q <= mag_b;
                        end
                        if (special) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= spec_res;
                        end else begin
                            state <= S_CALC;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - scoreboard bench for mul_div_unit
module tb_mul_div_unit;
    import md_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        kill;
    logic [3:0]  op;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic        busy;
    logic        done;
    logic [63:0] result;

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   cyc;
    int   n_checks;
    int   n_fail;

    mul_div_unit #(.XLEN(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && done) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done=1 result=%h at cycle %0d, expected no done", result, cyc);
            end else begin
                e_mon = sb.pop_front();
                if (result !== e_mon.res) begin
                    n_fail++;
                    $display("FAIL %s result: got %h expected %h", e_mon.name, result, e_mon.res);
                end
                n_checks++;
                if (cyc !== e_mon.due) begin
                    n_fail++;
                    $display("FAIL %s latency: done at cycle %0d expected %0d", e_mon.name, cyc, e_mon.due);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp_res, input int lat, input bit expect_done,
                         input string name);
        exp_t e;
        op    = o;
        rs1   = a;
        rs2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (expect_done) begin
            e.res  = exp_res;
            e.due  = cyc + lat;
            e.name = name;
            sb.push_back(e);
        end
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b expected 1", name, busy);
        end
    endtask

    task automatic wait_done(input int bound, input string name);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done !== 1'b1 && k < bound);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: done=%b after %0d cycles, expected 1", name, done, k);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        op    = 4'd0;
        rs1   = '0;
        rs2   = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mul();
        int k;
        int busy_cycles;
        issue(MD_MUL, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b1, "mul_7_m3");
        k = 0;
        busy_cycles = 0;
        do begin
            @(negedge clk);
            k++;
            if (busy === 1'b1) busy_cycles++;
        end while (done !== 1'b1 && k < 200);
        n_checks++;
        if (busy_cycles !== 65) begin
            n_fail++;
            $display("FAIL mul_busy_cycles: got %0d expected 65", busy_cycles);
        end
        issue(MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b1, "mulhu_max");
        wait_done(100, "mulhu_max");
        issue(MD_MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, "mulhsu_m1_2");
        wait_done(100, "mulhsu_m1_2");
    endtask

    task automatic test_back_to_back();
        issue(MD_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64, 1'b1, "div_m7_2");
        wait_done(100, "div_m7_2");
        issue(MD_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64, 1'b1, "rem_m7_2_b2b");
        wait_done(100, "rem_m7_2_b2b");
    endtask

    task automatic test_special();
        @(negedge clk);
        issue(MD_DIVU, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, "divu_by_zero");
        wait_done(5, "divu_by_zero");
        issue(MD_REM, 64'd5, 64'd0, 64'd5, 0, 1'b1, "rem_by_zero");
        wait_done(5, "rem_by_zero");
        issue(MD_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 0, 1'b1, "div_overflow");
        wait_done(5, "div_overflow");
        issue(MD_REM, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 0, 1'b1, "rem_overflow");
        wait_done(5, "rem_overflow");
        issue(4'd14, 64'd9, 64'd3, 64'h0, 0, 1'b1, "reserved_op");
        wait_done(5, "reserved_op");
    endtask

    task automatic test_w_ops();
        issue(MD_DIVW, 64'h0000_0001_8000_0000, 64'd2, 64'hFFFF_FFFF_C000_0000, 32, 1'b1, "divw");
        wait_done(60, "divw");
        issue(MD_MULW, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 32, 1'b1, "mulw");
        wait_done(60, "mulw");
    endtask

    task automatic test_kill();
        issue(MD_DIV, 64'd100, 64'd7, 64'h0, 64, 1'b0, "div_killed");
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1;
        kill = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL kill_done: got %b expected 0", done); end
        repeat (70) @(negedge clk);
        issue(MD_MUL, 64'd3, 64'd4, 64'd12, 64, 1'b1, "mul_after_kill");
        wait_done(100, "mul_after_kill");
    endtask

    task automatic test_rst_abort();
        @(negedge clk);
        issue(MD_DIV, 64'd100, 64'd7, 64'h0, 64, 1'b0, "div_reset");
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_abort_done: got %b expected 0", done); end
        n_checks++;
        if (result !== 64'h0) begin n_fail++; $display("FAIL rst_abort_result: got %h expected 0", result); end
        @(negedge clk);
        rst = 1'b0;
        repeat (70) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_abort_idle: busy got %b expected 0", busy); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mul();
        test_back_to_back();
        test_special();
        test_w_ops();
        test_kill();
        test_rst_abort();
        repeat (5) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending results expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
